// File: rtl/rv32i_top.sv
// rv32i_top: non-pipelined RV32I integer core with a two-state FETCH/MEM sequencer.
// Define RV32I_TOP_TRACE_EN to enable retire tracing on ir_type_from_id / jump_ex.
module rv32i_top #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ACKI_n,
    input  logic [31:0] IDT,
    input  logic        ACKD_n,
    input  logic [2:0]  OINT_n,
    output logic [31:0] IAD,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    output logic        IACK_n,
    inout  wire  [31:0] DDT,
    output logic [3:0]  ir_type_from_id,
    output logic        jump_ex
);
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef enum logic {FETCH, MEM} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] regs [1:31];
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, wb_val, next_pc, load_val;
    logic        wb_en, br_taken, is_mem, is_store;
    logic        unused_irq;

    assign unused_irq = ^OINT_n;
    assign IACK_n     = 1'b1;
    assign IAD        = pc;
    assign DDT        = (MREQ && WRITE) ? mem_wdata : 32'bz;

    assign opcode = IDT[6:0];
    assign rd     = IDT[11:7];
    assign funct3 = IDT[14:12];
    assign rs1    = IDT[19:15];
    assign rs2    = IDT[24:20];
    assign alt    = IDT[30];
    assign imm_i  = {{20{IDT[31]}}, IDT[31:20]};
    assign imm_s  = {{20{IDT[31]}}, IDT[31:25], IDT[11:7]};
    assign imm_b  = {{19{IDT[31]}}, IDT[31], IDT[7], IDT[30:25], IDT[11:8], 1'b0};
    assign imm_u  = {IDT[31:12], 12'd0};
    assign imm_j  = {{11{IDT[31]}}, IDT[31], IDT[19:12], IDT[20], IDT[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign is_mem   = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign is_store = (opcode == OPC_STORE);

    always_comb begin
        alu_b = (opcode == OPC_OP) ? rs2_val : imm_i;
        case (funct3)
            3'd0:    alu_y = (opcode == OPC_OP && alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_y = rs1_val << alu_b[4:0];
            3'd2:    alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_y = {31'd0, rs1_val < alu_b};
            3'd4:    alu_y = rs1_val ^ alu_b;
            3'd5:    alu_y = alt ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'd6:    alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    br_taken = (rs1_val == rs2_val);
            3'd1:    br_taken = (rs1_val != rs2_val);
            3'd4:    br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    br_taken = (rs1_val < rs2_val);
            3'd7:    br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Everything not listed falls through as a NOP that still advances the PC
    always_comb begin
        wb_en   = 1'b0;
        wb_val  = alu_y;
        next_pc = pc + 32'd4;
        case (opcode)
            OPC_OP, OPC_IMM: wb_en = 1'b1;
            OPC_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
            OPC_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
            OPC_JAL:   begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = pc + imm_j; end
            OPC_JALR:  begin wb_en = 1'b1; wb_val = pc + 32'd4; next_pc = (rs1_val + imm_i) & ~32'd1; end
            OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
            default: ;
        endcase
    end

    always_comb begin
        case (mem_funct3)
            3'd0:    load_val = {{24{DDT[7]}}, DDT[7:0]};
            3'd1:    load_val = {{16{DDT[15]}}, DDT[15:0]};
            3'd4:    load_val = {24'd0, DDT[7:0]};
            3'd5:    load_val = {16'd0, DDT[15:0]};
            default: load_val = DDT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            DAD        <= 32'd0;
            mem_rd     <= 5'd0;
            mem_funct3 <= 3'd0;
            mem_wdata  <= 32'd0;
            for (int i = 1; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            case (state)
                FETCH: if (!ACKI_n) begin
                    if (is_mem) begin
                        state      <= MEM;
                        MREQ       <= 1'b1;
                        WRITE      <= is_store;
                        SIZE       <= (funct3[1:0] == 2'd0) ? 2'b10 :
                                      (funct3[1:0] == 2'd1) ? 2'b01 : 2'b00;
                        DAD        <= rs1_val + (is_store ? imm_s : imm_i);
                        mem_rd     <= rd;
                        mem_funct3 <= funct3;
                        mem_wdata  <= rs2_val;
                    end else begin
                        pc <= next_pc;
                        if (wb_en && rd != 5'd0) regs[rd] <= wb_val;
                    end
                end
                MEM: if (!ACKD_n) begin
                    state <= FETCH;
                    MREQ  <= 1'b0;
                    WRITE <= 1'b0;
                    SIZE  <= 2'b00;
                    pc    <= pc + 32'd4;
                    if (!WRITE && mem_rd != 5'd0) regs[mem_rd] <= load_val;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef RV32I_TOP_TRACE_EN
    logic [3:0] type_c;

    always_comb begin
        case (opcode)
            OPC_OP:     type_c = 4'd0;
            OPC_IMM:    type_c = 4'd1;
            OPC_BRANCH: type_c = 4'd4;
            OPC_JAL:    type_c = 4'd5;
            OPC_JALR:   type_c = 4'd6;
            OPC_LUI:    type_c = 4'd7;
            OPC_AUIPC:  type_c = 4'd8;
            default:    type_c = 4'd9;
        endcase
    end

    // Loads/stores retire from MEM, so their code is written there rather than at fetch
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ir_type_from_id <= 4'd9;
            jump_ex         <= 1'b0;
        end else if (state == FETCH && !ACKI_n && !is_mem) begin
            ir_type_from_id <= type_c;
            jump_ex         <= (opcode == OPC_BRANCH && br_taken) ||
                               opcode == OPC_JAL || opcode == OPC_JALR;
        end else if (state == MEM && !ACKD_n) begin
            ir_type_from_id <= WRITE ? 4'd3 : 4'd2;
            jump_ex         <= 1'b0;
        end
    end
`else
    assign ir_type_from_id = 4'd0;
    assign jump_ex         = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_top.sv
// Scoreboard bench for rv32i_top: an ISA-level model predicts every fetch address and data access.
module tb_rv32i_top;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ACKI_n, ACKD_n;
    logic [31:0] IDT;
    logic [2:0]  OINT_n;
    logic [31:0] IAD, DAD;
    logic        MREQ, WRITE, IACK_n, jump_ex;
    logic [1:0]  SIZE;
    logic [3:0]  ir_type_from_id;
    wire  [31:0] DDT;
    logic        drv_en;
    logic [31:0] drv_val;

    assign DDT = drv_en ? drv_val : 32'bz;

    rv32i_top #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .ACKI_n(ACKI_n), .IDT(IDT), .ACKD_n(ACKD_n),
        .OINT_n(OINT_n), .IAD(IAD), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE),
        .SIZE(SIZE), .IACK_n(IACK_n), .DDT(DDT),
        .ir_type_from_id(ir_type_from_id), .jump_ex(jump_ex)
    );

    localparam logic [3:0] K_OP = 4'd0, K_IMM = 4'd1, K_LOAD = 4'd2, K_STORE = 4'd3,
                           K_BR = 4'd4, K_JAL = 4'd5, K_JALR = 4'd6, K_LUI = 4'd7,
                           K_AUIPC = 4'd8, K_MISC = 4'd9;

    typedef struct packed {
        logic [3:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
    } ins_t;

    typedef struct packed {
        logic        is_mem;
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  itype;
        logic        jump;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t expq[$];
    exp_t mon_e;
    logic mon_en = 1'b0;

    logic [31:0] m_x [0:31];
    logic [31:0] m_pc;
    logic [3:0]  m_type;
    logic        m_jump;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_type();
`ifdef RV32I_TOP_TRACE_EN
        return m_type;
`else
        return 4'd0;
`endif
    endfunction

    function automatic logic exp_jump();
`ifdef RV32I_TOP_TRACE_EN
        return m_jump;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        m_pc   = 32'd0;
        m_type = 4'd9;
        m_jump = 1'b0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_x[r] = v;
    endtask

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_exec(input ins_t t);
        logic [31:0] a, b, npc;
        logic        jmp, tk;
        a   = m_x[t.rs1];
        b   = m_x[t.rs2];
        npc = m_pc + 32'd4;
        jmp = 1'b0;
        case (t.kind)
            K_OP:    wr(t.rd, alu(t.f3, t.alt, a, b));
            K_IMM:   wr(t.rd, alu(t.f3, t.alt, a, t.imm));
            K_LUI:   wr(t.rd, t.imm);
            K_AUIPC: wr(t.rd, m_pc + t.imm);
            K_JAL:   begin wr(t.rd, m_pc + 32'd4); npc = m_pc + t.imm; jmp = 1'b1; end
            K_JALR:  begin npc = (a + t.imm) & 32'hFFFF_FFFE; wr(t.rd, m_pc + 32'd4); jmp = 1'b1; end
            K_BR: begin
                case (t.f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = ($signed(a) < $signed(b));
                    3'd5: tk = ($signed(a) >= $signed(b));
                    3'd6: tk = (a < b);
                    default: tk = (a >= b);
                endcase
                if (tk) begin npc = m_pc + t.imm; jmp = 1'b1; end
            end
            default: ;
        endcase
        m_pc   = npc;
        m_type = t.kind;
        m_jump = jmp;
    endtask

    task automatic model_mem_retire(input ins_t t, input logic [31:0] d);
        if (t.kind == K_LOAD) begin
            case (t.f3)
                3'd0: wr(t.rd, {{24{d[7]}}, d[7:0]});
                3'd1: wr(t.rd, {{16{d[15]}}, d[15:0]});
                3'd4: wr(t.rd, {24'd0, d[7:0]});
                3'd5: wr(t.rd, {16'd0, d[15:0]});
                default: wr(t.rd, d);
            endcase
        end
        m_pc   = m_pc + 32'd4;
        m_type = t.kind;
        m_jump = 1'b0;
    endtask

    function automatic logic [31:0] enc(input ins_t t);
        logic [31:0] i;
        i = t.imm;
        case (t.kind)
            K_OP:    return {t.alt ? 7'h20 : 7'h00, t.rs2, t.rs1, t.f3, t.rd, 7'h33};
            K_IMM:   if (t.f3 == 3'd1 || t.f3 == 3'd5)
                         return {t.alt ? 7'h20 : 7'h00, i[4:0], t.rs1, t.f3, t.rd, 7'h13};
                     else
                         return {i[11:0], t.rs1, t.f3, t.rd, 7'h13};
            K_LOAD:  return {i[11:0], t.rs1, t.f3, t.rd, 7'h03};
            K_STORE: return {i[11:5], t.rs2, t.rs1, t.f3, i[4:0], 7'h23};
            K_BR:    return {i[12], i[10:5], t.rs2, t.rs1, t.f3, i[4:1], i[11], 7'h63};
            K_JAL:   return {i[20], i[10:1], i[11], i[19:12], t.rd, 7'h6f};
            K_JALR:  return {i[11:0], t.rs1, 3'b000, t.rd, 7'h67};
            K_LUI:   return {i[31:12], t.rd, 7'h37};
            K_AUIPC: return {i[31:12], t.rd, 7'h17};
            default: return i;
        endcase
    endfunction

    function automatic ins_t mk(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                input logic [31:0] imm);
        ins_t t;
        t.kind = k; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.f3 = f3; t.alt = alt; t.imm = imm;
        return t;
    endfunction

    function automatic logic [4:0] reg_pick();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    function automatic ins_t gen();
        ins_t        t;
        int          r, o, v;
        logic [31:0] u;
        logic [11:0] s12;
        logic [20:0] s21;
        u = $urandom;
        s12 = u[11:0];
        t = '0;
        t.rd = reg_pick(); t.rs1 = reg_pick(); t.rs2 = reg_pick();
        t.imm = {{20{s12[11]}}, s12};
        r = int'($urandom_range(0, 99));
        if (r < 20) begin
            t.kind = K_OP; t.f3 = 3'($urandom_range(0, 7));
            t.alt = (t.f3 == 3'd0 || t.f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else if (r < 40) begin
            t.kind = K_IMM; t.f3 = 3'($urandom_range(0, 7));
            if (t.f3 == 3'd1 || t.f3 == 3'd5) t.imm = {27'd0, u[4:0]};
            t.alt = (t.f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else if (r < 52) begin
            t.kind = K_LOAD; v = int'($urandom_range(0, 4));
            t.f3 = (v < 3) ? 3'(v) : 3'(v + 1);
        end else if (r < 62) begin
            t.kind = K_STORE; t.f3 = 3'($urandom_range(0, 2));
        end else if (r < 74) begin
            t.kind = K_BR; v = int'($urandom_range(0, 5));
            t.f3 = (v < 2) ? 3'(v) : 3'(v + 2);
            o = int'($urandom_range(0, 32)) * 4 - 64;
            t.imm = 32'(o);
        end else if (r < 78) begin
            t.kind = K_JAL; s21 = u[20:0]; s21[0] = 1'b0;
            t.imm = {{11{s21[20]}}, s21};
        end else if (r < 84) begin
            t.kind = K_JALR;
        end else if (r < 89) begin
            t.kind = K_LUI; t.imm = {u[31:12], 12'd0};
        end else if (r < 94) begin
            t.kind = K_AUIPC; t.imm = {u[31:12], 12'd0};
        end else begin
            t.kind = K_MISC;
            case ($urandom_range(0, 5))
                0: t.imm = 32'h0000_000F;
                1: t.imm = 32'h0000_0073;
                2: t.imm = 32'h0010_0073;
                3: t.imm = 32'h3000_90F3;
                4: t.imm = 32'h0000_00FF;
                default: t.imm = {u[31:7], 7'h2B};
            endcase
        end
        return t;
    endfunction

    task automatic push_fetch();
        exp_t e;
        e = '0;
        e.addr  = m_pc;
        e.itype = exp_type();
        e.jump  = exp_jump();
        expq.push_back(e);
    endtask

    task automatic push_mem(input ins_t t);
        exp_t e;
        e = '0;
        e.is_mem = 1'b1;
        e.addr   = m_x[t.rs1] + t.imm;
        e.write  = (t.kind == K_STORE);
        e.size   = (t.f3[1:0] == 2'd0) ? 2'b10 : (t.f3[1:0] == 2'd1) ? 2'b01 : 2'b00;
        e.wdata  = m_x[t.rs2];
        expq.push_back(e);
    endtask

    // Called at a falling edge with the DUT expected in FETCH; returns at the falling edge after retire
    task automatic issue(input ins_t t, input logic [31:0] ldata, input int fs, input int ms);
        logic ld;
        ld = (t.kind == K_LOAD);
        push_fetch();
        OINT_n = 3'($urandom);
        for (int i = 0; i < fs; i++) begin
            ACKI_n = 1'b1; IDT = $urandom;
            @(negedge clk);
        end
        ACKI_n = 1'b0; IDT = enc(t);
        if (t.kind == K_LOAD || t.kind == K_STORE) begin
            push_mem(t);
            @(negedge clk);
            ACKI_n = 1'b1; IDT = $urandom;
            for (int i = 0; i < ms; i++) begin
                ACKD_n = 1'b1; drv_en = ld; drv_val = $urandom;
                @(negedge clk);
            end
            ACKD_n = 1'b0; drv_en = ld; drv_val = ldata;
            model_mem_retire(t, ldata);
            @(negedge clk);
            ACKD_n = 1'b1; drv_en = 1'b0;
        end else begin
            model_exec(t);
            @(negedge clk);
            ACKI_n = 1'b1; IDT = $urandom;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".iad"},    IAD, 32'd0);
        check({tag, ".mreq"},   32'(MREQ), 32'd0);
        check({tag, ".write"},  32'(WRITE), 32'd0);
        check({tag, ".size"},   32'(SIZE), 32'd0);
        check({tag, ".dad"},    DAD, 32'd0);
        check({tag, ".iack_n"}, 32'(IACK_n), 32'd1);
`ifdef RV32I_TOP_TRACE_EN
        check({tag, ".ir_type"}, 32'(ir_type_from_id), 32'd9);
`else
        check({tag, ".ir_type"}, 32'(ir_type_from_id), 32'd0);
`endif
        check({tag, ".jump_ex"}, 32'(jump_ex), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL queue_empty: DUT active with nothing expected, MREQ=%b IAD=%h", MREQ, IAD);
                end else begin
                    mon_e = expq[0];
                    check("mreq", 32'(MREQ), 32'(mon_e.is_mem));
                    if (!mon_e.is_mem) begin
                        check("iad", IAD, mon_e.addr);
                        check("fetch.write", 32'(WRITE), 32'd0);
                        check("fetch.size", 32'(SIZE), 32'd0);
                        check("iack_n", 32'(IACK_n), 32'd1);
                        check("ir_type", 32'(ir_type_from_id), 32'(mon_e.itype));
                        check("jump_ex", 32'(jump_ex), 32'(mon_e.jump));
                        if (!ACKI_n) void'(expq.pop_front());
                    end else begin
                        check("dad", DAD, mon_e.addr);
                        check("mem.write", 32'(WRITE), 32'(mon_e.write));
                        check("mem.size", 32'(SIZE), 32'(mon_e.size));
                        if (mon_e.write) check("store_data", DDT, mon_e.wdata);
                        if (!ACKD_n) void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t t;
        rst_n = 1'b1; ACKI_n = 1'b1; ACKD_n = 1'b1; IDT = 32'd0;
        OINT_n = 3'b111; drv_en = 1'b0; drv_val = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b0;
        mon_en = 1'b1;

        issue(mk(K_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5), 32'd0, 0, 0);
        issue(mk(K_LUI, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'h0800_0000), 32'd0, 0, 0);
        issue(mk(K_LOAD, 5'd2, 5'd3, 5'd0, 3'd2, 1'b0, 32'd0), 32'hDEAD_BEEF, 0, 0);
        issue(mk(K_STORE, 5'd0, 5'd0, 5'd2, 3'd2, 1'b0, 32'd0), 32'd0, 0, 0);
        issue(mk(K_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'h41), 32'd0, 0, 0);
        issue(mk(K_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hF000_0000), 32'd0, 0, 0);
        issue(mk(K_STORE, 5'd0, 5'd5, 5'd4, 3'd0, 1'b0, 32'd0), 32'd0, 0, 3);
        issue(mk(K_LOAD, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0), 32'h1234_5680, 0, 1);
        issue(mk(K_LOAD, 5'd7, 5'd0, 5'd0, 3'd4, 1'b0, 32'd0), 32'h1234_5680, 1, 0);
        issue(mk(K_STORE, 5'd0, 5'd0, 5'd6, 3'd2, 1'b0, 32'd0), 32'd0, 0, 0);
        issue(mk(K_STORE, 5'd0, 5'd0, 5'd7, 3'd2, 1'b0, 32'd0), 32'd0, 0, 0);
        issue(mk(K_BR, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8), 32'd0, 0, 0);
        issue(mk(K_BR, 5'd0, 5'd0, 5'd0, 3'd1, 1'b0, 32'd8), 32'd0, 0, 0);
        issue(mk(K_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h101), 32'd0, 0, 0);
        issue(mk(K_JALR, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd0), 32'd0, 2, 0);
        issue(mk(K_STORE, 5'd0, 5'd0, 5'd1, 3'd2, 1'b0, 32'd0), 32'd0, 2, 0);

        for (int n = 0; n < 400; n++) begin
            t = gen();
            issue(t, $urandom,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        for (int r = 1; r < 32; r++)
            issue(mk(K_STORE, 5'd0, 5'd0, 5'(r), 3'd2, 1'b0, 32'd0), 32'd0, 0, 0);

        // Load abandoned by a reset while waiting in MEM
        t = mk(K_LOAD, 5'd8, 5'd0, 5'd0, 3'd2, 1'b0, 32'd4);
        push_fetch();
        ACKI_n = 1'b0; IDT = enc(t);
        push_mem(t);
        @(negedge clk);
        ACKI_n = 1'b1; ACKD_n = 1'b1; drv_en = 1'b1; drv_val = 32'h5A5A_5A5A;
        @(negedge clk);
        mon_en = 1'b0;
        rst_n = 1'b1; ACKD_n = 1'b0;
        #1;
        check_reset("mid_mem_reset");
        @(negedge clk);
        rst_n = 1'b0; ACKD_n = 1'b1; drv_en = 1'b0;
        expq.delete();
        model_reset();
        mon_en = 1'b1;
        issue(mk(K_STORE, 5'd0, 5'd0, 5'd8, 3'd2, 1'b0, 32'd0), 32'd0, 0, 0);
        mon_en = 1'b0;
        check("queue_drained", 32'(expq.size()), 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rv32i_top.md
RV32I_TOP -- requirements
Module: rv32i_top

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-high reset (asserted when 1).
REQ-004 ACKI_n  in  1  instruction-fetch acknowledge, active low; IDT valid when 0.
REQ-005 IDT  in  32  instruction word for address IAD.
REQ-006 ACKD_n  in  1  data-access acknowledge, active low.
REQ-007 OINT_n  in  3  external interrupt requests, active low (ignored by this block).
REQ-008 IAD  out  32  instruction address (current PC).
REQ-009 DAD  out  32  data byte address.
REQ-010 MREQ  out  1  data memory request.
REQ-011 WRITE  out  1  1=store, 0=load; meaningful only with MREQ=1.
REQ-012 SIZE  out  2  00=word, 01=halfword, 10=byte.
REQ-013 IACK_n  out  1  interrupt acknowledge; held 1.
REQ-014 DDT  inout  32  data bus; value right-justified (byte in [7:0], half in [15:0]).
REQ-015 ir_type_from_id  out  4  type code of the most recently retired instruction.
REQ-016 jump_ex  out  1  1 when the most recently retired instruction redirected the PC.

Function
REQ-017 Non-pipelined RV32I base integer core; two-state FSM: FETCH, MEM.
REQ-018 FETCH: IAD=PC; IDT decoded combinationally; at rising edge with ACKI_n=0, non-memory instruction retires (rd write, PC update); ACKI_n=1 holds all state.
REQ-019 FETCH with ACKI_n=0 and LOAD/STORE: latch instruction, base+offset, store data; go to MEM; PC unchanged.
REQ-020 MEM: MREQ=1, DAD=rs1+imm, WRITE per opcode, SIZE per funct3; at edge with ACKD_n=0 retire (load writes rd), PC+=4, return to FETCH; ACKD_n=1 holds.
REQ-021 Loads: LB/LH sign-extend DDT[7:0]/[15:0]; LBU/LHU zero-extend; LW takes DDT[31:0]; DDT sampled at the acknowledging edge.
REQ-022 Stores: DDT driven with rs2 (right-justified, upper bits unmodified rs2) only when MREQ=1 and WRITE=1; otherwise DDT high-Z.
REQ-023 No alignment check; DAD passed unmodified.
REQ-024 ALU: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and immediate forms, shift amount [4:0], mod-2^32 arithmetic, LUI, AUIPC.
REQ-025 Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: taken -> PC+imm; JAL: rd=PC+4, PC+imm; JALR: rd=PC+4, PC=(rs1+imm)&~1; rs1 read before rd write (rd==rs1 safe).
REQ-026 x0 reads 0; writes to x0 discarded; 31 general registers x 32 bits.
REQ-027 FENCE, ECALL, EBREAK, CSR and undefined opcodes retire as NOP (PC+=4).
REQ-028 ir_type codes: 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 other; updated on each retire.
REQ-029 jump_ex=1 for taken branch, JAL, JALR on their retire; 0 for all others; updated on each retire.
REQ-030 MREQ=0, WRITE=0, SIZE=00 whenever in FETCH.

Reset
REQ-031 rst_n=1 asynchronously: PC=RESET_PC, state=FETCH, MREQ=0, WRITE=0, SIZE=00, DAD=0, IACK_n=1, DDT high-Z, ir_type_from_id=9, jump_ex=0; registers x1..x31=0.
REQ-032 Reset during MEM abandons the access; no register write occurs.

Configuration
REQ-033 Macro RV32I_TOP_TRACE_EN defined: ir_type_from_id and jump_ex behave per REQ-028/029.
REQ-034 Macro undefined: both ports still present, tied to 0, tracking logic removed; core behaviour otherwise identical.

Verification
REQ-035 Reset, then ACKI_n=0, IDT=ADDI x1,x0,5 -> after one edge x1=5, IAD=4.
REQ-036 LW x2,0(x3), x3=0x0800_0000, ACKD_n=0, DDT=0xDEADBEEF -> MREQ=1, WRITE=0, SIZE=00, DAD=0x0800_0000; x2=0xDEADBEEF; 2 cycles total.
REQ-037 SB x4,0(x5), x4=0x41, x5=0xF000_0000 -> MREQ=1, WRITE=1, SIZE=10, DDT[7:0]=0x41; ACKD_n=1 for 3 cycles holds state, ACKD_n=0 retires.
REQ-038 LB with DDT[7:0]=0x80 -> rd=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-039 BEQ x0,x0,+8 at PC=0x10 -> IAD=0x18, jump_ex=1, ir_type=4 (TRACE_EN); BNE x0,x0 -> IAD=0x14, jump_ex=0.
REQ-040 JALR x1,x1,0 with x1=0x101 -> PC=0x100, x1=old PC+4; ACKI_n=1 stall leaves PC unchanged.
